// File: rtl/writeback_pkg.sv
// Shared sizing and selection encoding for the minuteCore writeback stage.
// Width defaults mirror REG_ADDR_SIZE/REG_DATA_SIZE/WB_FIFO_DEPTH from def_params.v.
package writeback_pkg;

  localparam int REG_ADDR_SIZE = 4;
  localparam int REG_DATA_SIZE = 31;
  localparam int WB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_FIFO = 2'd1,
    SEL_LSU  = 2'd2,
    SEL_ALU  = 2'd3
  } wb_sel_e;

  function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_SIZE:0] idx);
    reg_onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding ALU results that lost arbitration.
// Supports simultaneous push and pop; depth must be a power of two.
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates ALU/LSU results onto the regfile write port
// and tracks pending destination registers for RAW stall detection.
module writeback
  import writeback_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_SIZE + 1,
  parameter int DATA_W     = REG_DATA_SIZE + 1,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [31:0]       busy,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable
);

  logic [ADDR_W+DATA_W-1:0] w_head;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_alu_live;
  logic                     w_lsu_live;
  logic                     w_push;
  logic                     w_pop;
  wb_sel_e                  w_sel;
  logic [ADDR_W-1:0]        w_nxt_addr;
  logic [DATA_W-1:0]        w_nxt_data;
  logic [31:0]              w_set;
  logic [31:0]              w_clr;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic [DATA_W-1:0]        r_wr_data;
  logic                     r_wr_enable;
  logic [31:0]              r_busy;

  wb_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({alu_rd, alu_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign alu_ready = !w_full;
  assign lsu_ready = !w_full;

  // rd == 0 results are handshaken but never reach the FIFO or the write port.
  assign w_alu_live = alu_valid && !w_full && (alu_rd != {ADDR_W{1'b0}});
  assign w_lsu_live = lsu_valid && !w_full && (lsu_rd != {ADDR_W{1'b0}});

  always_comb begin
    w_sel = SEL_IDLE;
    if (w_full) begin
      w_sel = SEL_FIFO;
    end else if (w_lsu_live) begin
      w_sel = SEL_LSU;
    end else if (!w_empty) begin
      w_sel = SEL_FIFO;
    end else if (w_alu_live) begin
      w_sel = SEL_ALU;
    end else begin
      w_sel = SEL_IDLE;
    end
  end

  assign w_pop  = (w_sel == SEL_FIFO);
  assign w_push = w_alu_live && (w_sel != SEL_ALU);

  always_comb begin
    w_nxt_addr = r_wr_addr;
    w_nxt_data = r_wr_data;
    case (w_sel)
      SEL_FIFO: {w_nxt_addr, w_nxt_data} = w_head;
      SEL_LSU:  {w_nxt_addr, w_nxt_data} = {lsu_rd, lsu_data};
      SEL_ALU:  {w_nxt_addr, w_nxt_data} = {alu_rd, alu_data};
      default:  {w_nxt_addr, w_nxt_data} = {r_wr_addr, r_wr_data};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_enable <= 1'b0;
      r_wr_addr   <= {ADDR_W{1'b0}};
      r_wr_data   <= {DATA_W{1'b0}};
    end else begin
      r_wr_enable <= (w_sel != SEL_IDLE);
      r_wr_addr   <= w_nxt_addr;
      r_wr_data   <= w_nxt_data;
    end
  end

  // The commit edge clears the bit; a same-edge issue re-sets it (newer writer wins).
  assign w_set = (issue_valid && (issue_rd != {ADDR_W{1'b0}})) ? reg_onehot(issue_rd) : 32'd0;
  assign w_clr = r_wr_enable ? reg_onehot(r_wr_addr) : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    end
  end

  assign busy      = r_busy;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_enable = r_wr_enable;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: a queue-based reference model predicts each
// regfile write and busy vector; a negedge monitor compares what the DUT emits.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0, lsu_rd = 5'd0, issue_rd = 5'd0;
  logic [31:0] alu_data = 32'd0, lsu_data = 32'd0;
  logic        alu_ready, lsu_ready, wr_enable;
  logic [31:0] busy, wr_data;
  logic [4:0]  wr_addr;

  always #5 clk = ~clk;

  writeback #(.ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [4:0] a; logic [31:0] d; int c; } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  wr_t         mq[$];
  exp_t        exp_q[$];
  logic [31:0] mbusy = 32'd0;
  bit          m_wen = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  bit          saw_backpressure = 1'b0;
  logic [31:0] rf [32];

  // Regfile stand-in: commits on the edge after wr_enable is seen.
  always @(posedge clk) if (wr_enable) rf[wr_addr] <= wr_data;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    mbusy   = 32'd0;
    m_wen   = 1'b0;
    m_waddr = 5'd0;
  endtask

  // One cycle of stimulus; the reference model predicts from the arbitration rules.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ird,
                      output bit aacc, output bit lacc);
    wr_t o, e;
    bit  full, have, used;
    @(negedge clk); #1;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    full = (mq.size() == 2);
    check("alu_ready", alu_ready, !full);
    check("lsu_ready", lsu_ready, !full);
    aacc = av && !full;
    lacc = lv && !full;
    have = 1'b0;
    used = 1'b0;
    o.a = 5'd0;
    o.d = 32'd0;
    if (full) begin
      o = mq.pop_front(); have = 1'b1;
    end else if (lacc && lrd != 5'd0) begin
      o.a = lrd; o.d = ld; have = 1'b1;
    end else if (mq.size() > 0) begin
      o = mq.pop_front(); have = 1'b1;
    end else if (aacc && ard != 5'd0) begin
      o.a = ard; o.d = ad; have = 1'b1; used = 1'b1;
    end
    if (aacc && ard != 5'd0 && !used) begin
      e.a = ard; e.d = ad; mq.push_back(e);
    end
    if (have) exp_q.push_back('{o.a, o.d, cyc + 1});
    if (m_wen) mbusy[m_waddr] = 1'b0;
    if (iv && ird != 5'd0) mbusy[ird] = 1'b1;
    m_wen = have;
    if (have) m_waddr = o.a;
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a, l;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, l);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    model_reset();
    #2;
    check("rst_wr_enable", wr_enable, 1'b0);
    check("rst_wr_addr", wr_addr, 5'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_lsu_ready", lsu_ready, 1'b1);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy", busy, mbusy);
      if (!alu_ready && !lsu_ready) saw_backpressure = 1'b1;
      if (wr_enable) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got x%0d=%0h expected no write (cycle %0d)", wr_addr, wr_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", wr_data, e.d);
          check("wr_latency", cyc, e.c);
        end
      end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
        tests++; fails++;
        $display("FAIL missing_write: got no write expected x%0d=%0h (cycle %0d)", exp_q[0].a, exp_q[0].d, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit a, l;
    bit pa_v, pl_v;
    logic [4:0] pa_rd, pl_rd;
    logic [31:0] pa_d, pl_d;
    int ai, li;

    do_reset();
    idle(2);

    // Direct ALU path and regfile visibility.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, a, l);
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, l);
    idle(1);
    #1;
    check("rf_x5", rf[5], 32'hDEAD_BEEF);
    check("busy_x5_clear", busy[5], 1'b0);

    // LSU beats ALU in the same cycle; ALU follows one cycle later.
    step(1'b1, 5'd4, 32'h0000_0022, 1'b1, 5'd3, 32'h0000_0011, 1'b0, 5'd0, a, l);
    idle(3);

    // Sustained LSU traffic plus ALU x1..x3 fills the FIFO.
    saw_backpressure = 1'b0;
    ai = 1;
    li = 0;
    for (int k = 0; k < 14; k++) begin
      step(ai <= 3, 5'(ai), 32'hA000_0000 + 32'(ai),
           li < 6, 5'(16 + li), 32'hB000_0000 + 32'(li), 1'b0, 5'd0, a, l);
      if (a) ai++;
      if (l) li++;
    end
    idle(4);
    check("fifo_backpressure_seen", saw_backpressure, 1'b1);
    check("full_drain", exp_q.size(), 0);

    // x0 results and x0 issues have no effect.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, a, l);
    idle(2);
    #1;
    check("x0_busy", busy, 32'd0);

    // Scoreboard set/clear collision on x7.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, a, l);
    step(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, l);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, a, l);
    #1;
    check("busy7_set_wins", busy[7], 1'b1);
    step(1'b1, 5'd7, 32'h0000_0078, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, l);
    idle(1);
    #1;
    check("busy7_second_clear", busy[7], 1'b0);
    check("rf_x7", rf[7], 32'h0000_0078);

    // Reset with two entries queued: nothing further may be written.
    step(1'b1, 5'd10, 32'h0000_0A0A, 1'b1, 5'd9, 32'h0000_0909, 1'b1, 5'd12, a, l);
    step(1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd11, 32'h0000_0B0B, 1'b0, 5'd0, a, l);
    do_reset();
    idle(4);

    // Randomized traffic; sources hold their offer until accepted.
    pa_v = 1'b0; pl_v = 1'b0;
    pa_rd = 5'd0; pl_rd = 5'd0; pa_d = 32'd0; pl_d = 32'd0;
    for (int k = 0; k < 600; k++) begin
      if (!pa_v && $urandom_range(0, 9) < 6) begin
        pa_v = 1'b1; pa_rd = 5'($urandom_range(0, 31)); pa_d = $urandom;
      end
      if (!pl_v && $urandom_range(0, 9) < 5) begin
        pl_v = 1'b1; pl_rd = 5'($urandom_range(0, 31)); pl_d = $urandom;
      end
      step(pa_v, pa_rd, pa_d, pl_v, pl_rd, pl_d,
           $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)), a, l);
      if (a) pa_v = 1'b0;
      if (l) pl_v = 1'b0;
    end
    idle(5);
    check("random_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
